// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// start/done handshake, sign handled by magnitude division plus final correction.
module div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     rem_ext;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_step;
   logic [WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;

   // One restoring step; trial kept one bit wider so its MSB is the borrow.
   always_comb begin
      rem_ext = {rem_q, quo_q[WIDTH-1]};
      trial   = rem_ext - {1'b0, dvs_q};
      if (trial[WIDTH]) begin
         rem_step = rem_ext[WIDTH-1:0];
         quo_step = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_step = trial[WIDTH-1:0];
         quo_step = {quo_q[WIDTH-2:0], 1'b1};
      end
      dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
      dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_rem_d = signed_op & dividend[WIDTH-1];
               if (divisor == '0) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  rem_d   = '0;
                  quo_d   = dvd_mag;
                  dvs_d   = dvs_mag;
               end
            end
         end
         CALC: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CNT_W'(1);
            // Last step lands straight in the result registers, sign-corrected.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d     = DONE;
               done_d      = 1'b1;
               quotient_d  = neg_quo_q ? -quo_step : quo_step;
               remainder_d = neg_rem_q ? -rem_step : rem_step;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: cycle-level transaction model (capture, latency, hold)
// with 64-bit reference arithmetic, directed corner cases and random pairs.
module tb_div_seq;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NRAND = 2000;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   div_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .signed_op  (signed_op),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Truncating division in 64-bit arithmetic; returns {quotient, remainder}.
   function automatic logic [63:0] ref_div(input logic sop, input logic [31:0] a,
                                           input logic [31:0] b);
      longint x, y, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      x  = sop ? longint'($signed(a)) : longint'({32'd0, a});
      y  = sop ? longint'($signed(b)) : longint'({32'd0, b});
      q  = x / y;
      r  = x % y;
      qv = q;
      rv = r;
      return {qv[31:0], rv[31:0]};
   endfunction

   // Transaction model: k counts edges since capture, lat is edges to result.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_q    = '0;
   logic [31:0] m_r    = '0;
   logic        m_dbz  = 1'b0;
   logic [63:0] m_res  = '0;
   int          m_k    = 0;
   int          m_lat  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_dbz  = 1'b0;
         m_k    = 0;
      end else begin
         if (!m_busy) begin
            if (start) begin
               m_res  = ref_div(signed_op, dividend, divisor);
               m_lat  = (divisor == '0) ? 0 : WIDTH;
               m_busy = 1'b1;
               m_k    = 0;
               m_dbz  = (divisor == '0);
               if (m_lat == 0) begin
                  m_q = m_res[63:32];
                  m_r = m_res[31:0];
               end
            end
         end else begin
            m_k++;
            if (m_k == m_lat) begin
               m_q = m_res[63:32];
               m_r = m_res[31:0];
            end
            if (m_k == m_lat + 1) m_busy = 1'b0;
         end
         m_done = m_busy && (m_k == m_lat);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_done));
         chk("quotient", 64'(quotient), 64'(m_q));
         chk("remainder", 64'(remainder), 64'(m_r));
         chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      end
   end

   // One operation from idle; optional stray start pulses mid-CALC and in DONE.
   task automatic run_op(input string nm, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic edbz, input bit stray);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      signed_op = sop;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom);
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         start = stray && (n == 10);
      end
      start = 1'b0;
      chk({nm, "_latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'(WIDTH + 1));
      chk({nm, "_q"}, 64'(quotient), 64'(eq));
      chk({nm, "_r"}, 64'(remainder), 64'(er));
      chk({nm, "_dbz"}, 64'(div_by_zero), 64'(edbz));
      if (stray) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         chk({nm, "_stray_idle"}, 64'(busy), 64'd0);
         chk({nm, "_stray_q"}, 64'(quotient), 64'(eq));
      end
   endtask

   initial begin
      logic [63:0] res;
      logic [31:0] a, b, q, r;
      logic        sop;
      longint      ma, mb, mr;
      int          n, t1, t2;

      rst_n     = 1'b0;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_q", 64'(quotient), 64'd0);
      chk("rst_r", 64'(remainder), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of an operation.
      signed_op = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_q", 64'(quotient), 64'd0);
      chk("mid_rst_r", 64'(remainder), 64'd0);
      chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      run_op("r100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

      run_op("u_ffff", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
      run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
      run_op("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("dbz_u", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
      run_op("dbz_s", 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
      run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
      run_op("stray", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b1);

      // start held high across two operations.
      signed_op = 1'b0;
      dividend  = 32'd50;
      divisor   = 32'd5;
      start     = 1'b1;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      chk("held1_seen", 64'(done), 64'd1);
      chk("held1_q", 64'(quotient), 64'd10);
      chk("held1_r", 64'(remainder), 64'd0);
      dividend = 32'd9;
      divisor  = 32'd4;
      @(negedge clk);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      t2 = cyc;
      start = 1'b0;
      chk("held2_seen", 64'(done), 64'd1);
      chk("held_gap", 64'(t2 - t1), 64'(WIDTH + 2));
      chk("held2_q", 64'(quotient), 64'd2);
      chk("held2_r", 64'(remainder), 64'd1);

      // Random pairs, checked against the reference and the division identity.
      for (int i = 0; i < NRAND; i++) begin
         sop = 1'($urandom);
         a   = $urandom;
         b   = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         if (sop && ($urandom_range(0, 1) == 0)) b = -b;
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 40));
         if (b == 32'd0) b = 32'd1;
         res = ref_div(sop, a, b);
         run_op("rand", sop, a, b, res[63:32], res[31:0], 1'b0, 1'b0);
         q = quotient;
         r = remainder;
         chk("rand_identity", 64'(32'(q * b + r)), 64'(a));
         ma = sop ? longint'($signed(a)) : longint'({32'd0, a});
         mb = sop ? longint'($signed(b)) : longint'({32'd0, b});
         mr = sop ? longint'($signed(r)) : longint'({32'd0, r});
         if (mb < 0) mb = -mb;
         chk("rand_rem_mag", 64'(((mr < 0) ? -mr : mr) < mb), 64'd1);
         chk("rand_rem_sign", 64'((mr == 0) || ((mr < 0) == (ma < 0))), 64'd1);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
